point_add_dbl: RTL and testbench
================================

POINT_ADD_DBL -- requirements
Module: point_add_dbl

Interface
REQ-001 SHALL have parameter N, default 231, operand/field width in bits.
REQ-002 SHALL have parameter INV_TIMEOUT, default 4*N, max inverse cycles before error.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 op  input  1  0 = add (P1+P2), 1 = double (2*P1, P2 ignored).
REQ-007 p, a  input  N each  field prime (odd, >3), curve coefficient a (< p).
REQ-008 x1, y1, x2, y2  input  N each  affine coordinates, each < p.
REQ-009 inf1, inf2  input  1 each  operand is point at infinity (coordinates ignored).
REQ-010 busy  output  1  high from cycle after accepted start until done.
REQ-011 done  output  1  one-cycle pulse; results valid from this cycle until next accepted start.
REQ-012 x3, y3  output  N each  result coordinates; 0 when inf3 = 1.
REQ-013 inf3  output  1  result is point at infinity.
REQ-014 err  output  1  inverse exceeded INV_TIMEOUT; qualified by done.

Function
REQ-015 SHALL register all inputs on accepted start; input changes while busy have no effect.
REQ-016 FSM states: IDLE, CHECK, INV, LAM, X3, Y3, FIN; start in IDLE -> CHECK, else stay.
REQ-017 CHECK, add: inf1 -> result P2; inf2 -> result P1; x1==x2 and y1+y2 == 0 or p -> inf3; x1==x2 and y1==y2 -> double path; else add path, denominator x2-x1 mod p.
REQ-018 CHECK, double: inf1 or y1==0 -> inf3; else denominator 2*y1 mod p, numerator 3*x1^2+a mod p.
REQ-019 Special-case results SHALL go CHECK -> FIN; done asserts exactly 2 cycles after the start cycle.
REQ-020 INV SHALL start sub-module once, wait for its done, then -> LAM; counter overrun of INV_TIMEOUT -> FIN with err=1, inf3=0, x3=y3=0.
REQ-021 LAM: lambda = num*inv mod p; X3: x3 = lambda^2 - xa - xb mod p; Y3: y3 = lambda*(x1-x3) - y1 mod p; one state each, one cycle each.
REQ-022 Modular products SHALL use 2N-bit intermediate then reduce; subtractions add p when negative; all results in [0, p-1].
REQ-023 FIN: drive done=1 for one cycle, busy=0 same cycle, -> IDLE; start in FIN cycle is ignored.
REQ-024 General-path latency = 5 + inverse cycles; fixed for given operands.
REQ-025 x3/y3/inf3/err SHALL hold between done and next accepted start.

Reset
REQ-026 reset SHALL override all activity, including mid-operation: state IDLE, busy=0, done=0, err=0, inf3=0, x3=y3=0, sub-module aborted.
REQ-027 start asserted in the reset cycle SHALL be ignored.

Structure
REQ-028 Shared package ecc_pkg SHALL hold the op encoding (OP_ADD, OP_DBL) and the FSM state type.
REQ-029 One sub-module mod_inv (iterative binary extended Euclid, start/done/x handshake, parameter N) SHALL compute denominator inverse; all other arithmetic in point_add_dbl.

Verification (curve y^2=x^3+2x+2 mod 17, N=8 unless stated)
REQ-030 op=1, P1=(5,1) -> done, x3=6, y3=3, inf3=0, err=0.
REQ-031 op=0, P1=(5,1), P2=(6,3) -> x3=10, y3=6; op=0, P1=P2=(5,1) -> (6,3) via double path.
REQ-032 op=0, P1=(5,1), P2=(5,16) -> inf3=1, x3=y3=0, done exactly 2 cycles after start.
REQ-033 op=0, inf1=1, P2=(6,3) -> (6,3) in 2 cycles; op=1, y1=0 -> inf3=1.
REQ-034 reset asserted in INV of REQ-030 run -> next cycle busy=0, outputs 0; rerun yields (6,3); start pulses while busy ignored.
REQ-035 N=231 default, random points on chosen curve compared against software model, done count equals accepted-start count.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared encodings for the elliptic-curve point add/double block.
package ecc_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_DBL = 1'b1} op_e;
  typedef enum logic [2:0] {IDLE, CHECK, INV, LAM, X3, Y3, FIN} state_e;
endpackage

// File: rtl/point_add_dbl_if.sv
// Request/result bundle for point_add_dbl; slave side is the engine.
interface point_add_dbl_if #(parameter int N = 231);
  logic         start, op, inf1, inf2;
  logic [N-1:0] p, a, x1, y1, x2, y2;
  logic         busy, done, inf3, err;
  logic [N-1:0] x3, y3;

  modport master (output start, op, inf1, inf2, p, a, x1, y1, x2, y2,
                  input  busy, done, inf3, err, x3, y3);
  modport slave  (input  start, op, inf1, inf2, p, a, x1, y1, x2, y2,
                  output busy, done, inf3, err, x3, y3);
endinterface

// File: rtl/mod_inv.sv
// Iterative binary extended Euclid: x = a^-1 mod p (p odd), one step per cycle.
module mod_inv #(parameter int N = 231) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] p,
  input  logic [N-1:0] a,
  output logic         done,
  output logic [N-1:0] x
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic         run;
  logic [N-1:0] u, v, b1, b2;

  function automatic logic [N-1:0] half(input logic [N-1:0] z, input logic [N-1:0] m);
    logic [N:0] t;
    t = z[0] ? {1'b0, z} + {1'b0, m} : {1'b0, z};
    return t[N:1];
  endfunction

  function automatic logic [N-1:0] subm(input logic [N-1:0] s, input logic [N-1:0] t,
                                        input logic [N-1:0] m);
    return (s >= t) ? s - t : s + (m - t);
  endfunction

  // Invariants: b1*a == u and b2*a == v (mod p); odd-odd steps fold the halving in.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      run <= 1'b0; x <= '0;
      u <= '0; v <= '0; b1 <= '0; b2 <= '0;
    end else if (start) begin
      run <= 1'b1;
      u <= a; v <= p; b1 <= ONE; b2 <= '0;
    end else if (run) begin
      if (u == ONE)      begin run <= 1'b0; done <= 1'b1; x <= b1; end
      else if (v == ONE) begin run <= 1'b0; done <= 1'b1; x <= b2; end
      else if (!u[0])    begin u <= u >> 1; b1 <= half(b1, p); end
      else if (!v[0])    begin v <= v >> 1; b2 <= half(b2, p); end
      else if (u >= v)   begin u <= (u - v) >> 1; b1 <= half(subm(b1, b2, p), p); end
      else               begin v <= (v - u) >> 1; b2 <= half(subm(b2, b1, p), p); end
    end
  end
endmodule

// File: rtl/point_add_dbl.sv
// Affine point add / double over GF(p); inverse in mod_inv, the rest here.
module point_add_dbl
  import ecc_pkg::*;
#(parameter int N = 231, parameter int INV_TIMEOUT = 4 * N) (
  input logic       clk,
  input logic       reset,
  point_add_dbl_if.slave bus
);
  localparam int CW = $clog2(INV_TIMEOUT + 1) + 1;

  state_e         state, nxt;
  op_e            op_r;
  logic           inf1_r, inf2_r, inf3_r, err_r;
  logic [N-1:0]   p_r, a_r, x1_r, y1_r, x2_r, y2_r;
  logic [N-1:0]   num_r, den_r, xb_r, lam_r, x3_r, y3_r;
  logic [CW-1:0]  cnt;
  logic           inv_start, inv_done, inv_rst, timeout;
  logic [N-1:0]   inv_x;

  logic           special, sp_inf, use_dbl;
  logic [N-1:0]   sp_x, sp_y, sq, num_dbl, num_c, den_c, xb_c;
  logic [N:0]     ysum;

  function automatic logic [N-1:0] addm(input logic [N-1:0] s, input logic [N-1:0] t,
                                        input logic [N-1:0] m);
    logic [N:0] r;
    r = {1'b0, s} + {1'b0, t};
    if (r >= {1'b0, m}) r = r - {1'b0, m};
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] subm(input logic [N-1:0] s, input logic [N-1:0] t,
                                        input logic [N-1:0] m);
    return (s >= t) ? s - t : s + (m - t);
  endfunction

  function automatic logic [N-1:0] mulm(input logic [N-1:0] s, input logic [N-1:0] t,
                                        input logic [N-1:0] m);
    logic [2*N-1:0] pr;
    pr = {{N{1'b0}}, s} * {{N{1'b0}}, t};
    pr = pr % {{N{1'b0}}, m};
    return pr[N-1:0];
  endfunction

  // Operand classification and lambda numerator/denominator, consumed in CHECK.
  always_comb begin
    ysum    = {1'b0, y1_r} + {1'b0, y2_r};
    sq      = mulm(x1_r, x1_r, p_r);
    num_dbl = addm(addm(addm(sq, sq, p_r), sq, p_r), a_r, p_r);
    special = 1'b0; sp_inf = 1'b0; sp_x = '0; sp_y = '0;
    use_dbl = (op_r == OP_DBL);
    if (op_r == OP_ADD) begin
      if (inf1_r) begin
        special = 1'b1; sp_inf = inf2_r;
        sp_x = inf2_r ? '0 : x2_r; sp_y = inf2_r ? '0 : y2_r;
      end else if (inf2_r) begin
        special = 1'b1; sp_x = x1_r; sp_y = y1_r;
      end else if (x1_r == x2_r && (ysum == '0 || ysum == {1'b0, p_r})) begin
        special = 1'b1; sp_inf = 1'b1;
      end else if (x1_r == x2_r && y1_r == y2_r) begin
        use_dbl = 1'b1;
      end
    end else if (inf1_r || y1_r == '0) begin
      special = 1'b1; sp_inf = 1'b1;
    end
    num_c = use_dbl ? num_dbl : subm(y2_r, y1_r, p_r);
    den_c = use_dbl ? addm(y1_r, y1_r, p_r) : subm(x2_r, x1_r, p_r);
    xb_c  = use_dbl ? x1_r : x2_r;
  end

  assign timeout = !inv_done && (cnt >= CW'(INV_TIMEOUT));

  always_comb begin
    nxt       = state;
    inv_start = 1'b0;
    case (state)
      IDLE:    if (bus.start) nxt = CHECK;
      CHECK:   nxt = special ? FIN : INV;
      INV: begin
        inv_start = (cnt == '0);
        if (inv_done)     nxt = LAM;
        else if (timeout) nxt = FIN;
      end
      LAM:     nxt = X3;
      X3:      nxt = Y3;
      Y3:      nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= OP_ADD; inf1_r <= 1'b0; inf2_r <= 1'b0; inf3_r <= 1'b0; err_r <= 1'b0;
      p_r <= '0; a_r <= '0; x1_r <= '0; y1_r <= '0; x2_r <= '0; y2_r <= '0;
      num_r <= '0; den_r <= '0; xb_r <= '0; lam_r <= '0; x3_r <= '0; y3_r <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_r <= op_e'(bus.op); inf1_r <= bus.inf1; inf2_r <= bus.inf2;
          p_r <= bus.p; a_r <= bus.a;
          x1_r <= bus.x1; y1_r <= bus.y1; x2_r <= bus.x2; y2_r <= bus.y2;
          cnt <= '0;
        end
        CHECK: begin
          err_r <= 1'b0; inf3_r <= sp_inf;
          x3_r <= sp_x;  y3_r <= sp_y;
          num_r <= num_c; den_r <= den_c; xb_r <= xb_c;
        end
        INV: begin
          cnt <= cnt + 1'b1;
          if (timeout) begin
            err_r <= 1'b1; inf3_r <= 1'b0; x3_r <= '0; y3_r <= '0;
          end
        end
        LAM: lam_r <= mulm(num_r, inv_x, p_r);
        X3:  x3_r  <= subm(subm(mulm(lam_r, lam_r, p_r), x1_r, p_r), xb_r, p_r);
        Y3:  y3_r  <= subm(mulm(lam_r, subm(x1_r, x3_r, p_r), p_r), y1_r, p_r);
        default: ;
      endcase
    end
  end

  // A timed-out inverse is abandoned so it cannot leak a late done.
  assign inv_rst = reset || (state == INV && nxt == FIN);

  mod_inv #(.N(N)) u_inv (
    .clk   (clk),
    .reset (inv_rst),
    .start (inv_start),
    .p     (p_r),
    .a     (den_r),
    .done  (inv_done),
    .x     (inv_x)
  );

  assign bus.busy = (state == CHECK) || (state == INV) || (state == LAM) ||
                    (state == X3) || (state == Y3);
  assign bus.done = (state == FIN);
  assign bus.x3   = x3_r;
  assign bus.y3   = y3_r;
  assign bus.inf3 = inf3_r;
  assign bus.err  = err_r;
endmodule

// File: tb/tb_point_add_dbl.sv
// Directed vectors on y^2=x^3+2x+2 mod 17 (N=8) plus a wide run against a Fermat-inverse model.
module tb_point_add_dbl;
  localparam int W = 231;
  typedef logic [W-1:0] w_t;
  localparam w_t PW = (w_t'(1) << 127) - w_t'(1);

  typedef struct {
    string      name;
    logic       op, inf1, inf2;
    logic [7:0] x1, y1, x2, y2;
    logic [7:0] ex, ey;
    logic       einf, eerr;
    int         elat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0, checks = 0;
  int   wstarts = 0, wdones = 0;

  always #5 clk = ~clk;

  point_add_dbl_if #(.N(8)) b8 ();
  point_add_dbl_if #(.N(W)) bw ();

  point_add_dbl #(.N(8)) dut  (.clk(clk), .reset(reset), .bus(b8.slave));
  point_add_dbl          dutw (.clk(clk), .reset(reset), .bus(bw.slave));

  always @(posedge clk) if (bw.done) wdones <= wdones + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // pulse_at > 0 fires a conflicting start (and changes x1/op) while busy.
  task automatic run8(input vec_t v, input int pulse_at, output int lat);
    @(posedge clk); #1;
    b8.p = 8'd17; b8.a = 8'd2; b8.op = v.op; b8.inf1 = v.inf1; b8.inf2 = v.inf2;
    b8.x1 = v.x1; b8.y1 = v.y1; b8.x2 = v.x2; b8.y2 = v.y2; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    lat = 1;
    chk($sformatf("%s busy", v.name), W'(b8.busy), W'(1));
    while (!b8.done && lat < 200) begin
      if (lat == pulse_at) begin b8.start = 1'b1; b8.op = ~v.op; b8.x1 = 8'd6; end
      else b8.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    b8.start = 1'b0;
    chk($sformatf("%s done", v.name), W'(b8.done), W'(1));
    chk($sformatf("%s x3", v.name),   W'(b8.x3),   W'(v.ex));
    chk($sformatf("%s y3", v.name),   W'(b8.y3),   W'(v.ey));
    chk($sformatf("%s inf3", v.name), W'(b8.inf3), W'(v.einf));
    chk($sformatf("%s err", v.name),  W'(b8.err),  W'(v.eerr));
    if (v.elat != 0) chk($sformatf("%s latency", v.name), W'(lat), W'(v.elat));
  endtask

  function automatic w_t mm(input w_t x, input w_t y);
    logic [2*W-1:0] t;
    t = ({{W{1'b0}}, x} * {{W{1'b0}}, y}) % {{W{1'b0}}, PW};
    return t[W-1:0];
  endfunction
  function automatic w_t am(input w_t x, input w_t y);
    return (x + y) % PW;
  endfunction
  function automatic w_t sm(input w_t x, input w_t y);
    return (x + PW - y) % PW;
  endfunction
  function automatic w_t minv(input w_t d);
    w_t r, b, e;
    r = w_t'(1); b = d; e = PW - w_t'(2);
    for (int i = 0; i < 128; i++) begin
      if (e[i]) r = mm(r, b);
      b = mm(b, b);
    end
    return r;
  endfunction
  function automatic w_t rnd();
    logic [127:0] t;
    w_t v;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    v = w_t'(t[126:0]);
    return (v == PW) ? '0 : v;
  endfunction

  task automatic runw(input string nm, input logic op, input w_t a, input w_t x1,
                      input w_t y1, input w_t x2, input w_t y2);
    w_t s, num, den, xb, lam, ex, ey;
    int cyc;
    if (op) begin
      s = mm(x1, x1); num = am(am(am(s, s), s), a); den = am(y1, y1); xb = x1;
    end else begin
      num = sm(y2, y1); den = sm(x2, x1); xb = x2;
    end
    lam = mm(num, minv(den));
    ex  = sm(sm(mm(lam, lam), x1), xb);
    ey  = sm(mm(lam, sm(x1, ex)), y1);
    @(posedge clk); #1;
    bw.p = PW; bw.a = a; bw.op = op; bw.inf1 = 1'b0; bw.inf2 = 1'b0;
    bw.x1 = x1; bw.y1 = y1; bw.x2 = x2; bw.y2 = y2; bw.start = 1'b1;
    wstarts++;
    @(posedge clk); #1;
    bw.start = 1'b0;
    cyc = 0;
    while (!bw.done && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    chk({nm, " done"}, W'(bw.done), W'(1));
    chk({nm, " x3"}, bw.x3, ex);
    chk({nm, " y3"}, bw.y3, ey);
    chk({nm, " inf3"}, W'(bw.inf3), '0);
    chk({nm, " err"}, W'(bw.err), '0);
  endtask

  vec_t vecs[13];

  initial begin
    int lat, lat0, lat_b;
    w_t a, x1, y1, x2, y2;
    b8.start = 0; b8.op = 0; b8.inf1 = 0; b8.inf2 = 0; b8.p = 0; b8.a = 0;
    b8.x1 = 0; b8.y1 = 0; b8.x2 = 0; b8.y2 = 0;
    bw.start = 0; bw.op = 0; bw.inf1 = 0; bw.inf2 = 0; bw.p = 0; bw.a = 0;
    bw.x1 = 0; bw.y1 = 0; bw.x2 = 0; bw.y2 = 0;

    //          name        op inf1 inf2 x1 y1 x2 y2   ex ey inf err lat
    vecs[0]  = '{"dbl51",    1, 0, 0,  5, 1, 0, 0,     6, 3, 0, 0, 0};
    vecs[1]  = '{"add5163",  0, 0, 0,  5, 1, 6, 3,    10, 6, 0, 0, 0};
    vecs[2]  = '{"addsame",  0, 0, 0,  5, 1, 5, 1,     6, 3, 0, 0, 0};
    vecs[3]  = '{"addneg",   0, 0, 0,  5, 1, 5, 16,    0, 0, 1, 0, 2};
    vecs[4]  = '{"addinf1",  0, 1, 0,  9, 9, 6, 3,     6, 3, 0, 0, 2};
    vecs[5]  = '{"dbly0",    1, 0, 0,  3, 0, 0, 0,     0, 0, 1, 0, 2};
    vecs[6]  = '{"add2g3g",  0, 0, 0,  6, 3, 10, 6,    9, 16, 0, 0, 0};
    vecs[7]  = '{"dbl63",    1, 0, 0,  6, 3, 0, 0,     3, 1, 0, 0, 0};
    vecs[8]  = '{"addinf2",  0, 0, 1,  5, 1, 7, 7,     5, 1, 0, 0, 2};
    vecs[9]  = '{"addinfbo", 0, 1, 1,  5, 1, 6, 3,     0, 0, 1, 0, 2};
    vecs[10] = '{"dblinf",   1, 1, 0,  5, 1, 0, 0,     0, 0, 1, 0, 2};
    vecs[11] = '{"addy0",    0, 0, 0,  3, 0, 3, 0,     0, 0, 1, 0, 2};
    vecs[12] = '{"invtmo",   0, 0, 0,  5, 1, 5, 3,     0, 0, 0, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", W'(b8.busy), '0);
    chk("rst done", W'(b8.done), '0);
    chk("rst x3",   W'(b8.x3),   '0);
    chk("rst y3",   W'(b8.y3),   '0);
    chk("rst inf3", W'(b8.inf3), '0);
    chk("rst err",  W'(b8.err),  '0);
    reset = 1'b0;

    lat0 = 0;
    foreach (vecs[i]) begin
      run8(vecs[i], 0, lat);
      if (i == 0) lat0 = lat;
    end

    // results hold while inputs wiggle, then reset clears them
    run8(vecs[1], 0, lat);
    b8.x1 = 8'd0; b8.y1 = 8'd0; b8.op = 1'b1; b8.inf1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("hold x3", W'(b8.x3), W'(10));
    chk("hold y3", W'(b8.y3), W'(6));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst hold x3", W'(b8.x3), '0);
    chk("rst hold y3", W'(b8.y3), '0);

    // reset mid-inverse, with a start in the reset cycle
    @(posedge clk); #1;
    b8.op = 1'b1; b8.inf1 = 1'b0; b8.inf2 = 1'b0; b8.x1 = 8'd5; b8.y1 = 8'd1;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("inv busy", W'(b8.busy), W'(1));
    reset = 1'b1; b8.start = 1'b1; b8.op = 1'b0; b8.x1 = 8'd6; b8.y1 = 8'd3;
    b8.x2 = 8'd10; b8.y2 = 8'd6;
    @(posedge clk); #1;
    reset = 1'b0; b8.start = 1'b0;
    chk("abort busy", W'(b8.busy), '0);
    chk("abort done", W'(b8.done), '0);
    chk("abort inf3", W'(b8.inf3), '0);
    chk("abort err",  W'(b8.err),  '0);
    @(posedge clk); #1;
    chk("rst start ignored", W'(b8.busy), '0);

    run8(vecs[0], 3, lat_b);
    chk("latency fixed", W'(lat_b), W'(lat0));
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    chk("fin start ignored", W'(b8.busy), '0);

    for (int k = 0; k < 3; k++) begin
      a = rnd(); x1 = rnd(); y1 = rnd(); x2 = rnd(); y2 = rnd();
      if (y1 == '0) y1 = w_t'(1);
      if (x1 == x2) x2 = am(x2, w_t'(1));
      runw($sformatf("wadd%0d", k), 1'b0, a, x1, y1, x2, y2);
      runw($sformatf("wdbl%0d", k), 1'b1, a, x1, y1, x2, y2);
    end
    @(posedge clk); #1;
    chk("wide done count", W'(wdones), W'(wstarts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
